muskbus_reader: RTL
===================

Name: muskbus_reader

Overview:
Read-side counterpart of the Muskbus write master. Accepts a single-cycle read request for one 512-bit cache line from a client and bids for the bus. It issues a READ_MEM_TAG request carrying the line address, then collects eight 64-bit response beats, acknowledging each one. It returns the assembled line to the client with a one-cycle respcyc pulse. Sits between a cache/fetch unit and the Muskbus Top modport.

Parameters:
BEATS, 8, number of response beats per line
BEAT_W, 64, bits per beat; line width = BEATS*BEAT_W (512)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bus  modport  Muskbus.Top  drives bid, reqcyc, reqtag, req, respack; samples reqack, respcyc, resptag, resp
reqcyc  in  1  client read request; sampled only in IDLE
addr  in  64  line address; sampled when reqcyc is accepted
respcyc  out  1  one-cycle pulse: data holds a complete line
data  out  BEATS*BEAT_W  assembled line, indexed [0:511]; beat k occupies data[k*64 +: 64]

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- Reset: state=IDLE; beat counter=0; latched addr=0; data=0; respcyc=0. All bus outputs (bid, reqcyc, reqtag, req, respack) = 0.
- Reset mid-operation aborts the transfer unconditionally. No beats are acknowledged in the reset cycle.
- Default bus outputs are 0 every cycle unless a state below drives them.
- IDLE:
  - reqcyc=1 → latch addr, clear beat counter, go to REQ.
  - Client reqcyc in any other state is ignored; there is no queueing.
- REQ:
  - bid=1, bus.reqcyc=1, reqtag=MUSKBUS::READ_MEM_TAG, req=latched addr.
  - Hold these every cycle until bus.reqack=1, then go to RECV.
  - bus.respcyc is ignored in REQ; respack=0.
- RECV:
  - bid=0, bus.reqcyc=0.
  - A beat is accepted when bus.respcyc=1 and resptag==READ_MEM_TAG. In that same cycle, respack=1 (combinational).
  - On the clock edge, data[cnt*64 +: 64] <= bus.resp and cnt <= cnt+1.
  - A beat with a non-matching tag gets no respack and is not stored.
  - Gaps between beats are allowed, with no timeout.
  - When the accepted beat is cnt==BEATS-1, go to DONE.
- DONE:
  - respcyc=1 for exactly one cycle, then go to IDLE.
- data holds its value from the last beat until the first beat of the next transaction overwrites it. It is not cleared on entry to IDLE.
- Beat counter is $clog2(BEATS)+1 bits wide and never wraps within a transaction.
- Minimum latency:
  - client reqcyc at cycle T → bus.reqcyc at T+1.
  - If reqack arrives at T+1 and beats arrive back-to-back from T+2, beats land at T+2..T+9.
  - Client respcyc at T+10.
- Client may assert reqcyc in the same cycle respcyc is high. It is ignored because state is DONE, not IDLE; the client re-asserts in IDLE.

Decomposition:
- MUSKBUS package holds READ_MEM_TAG and WRITE_MEM_TAG (shared with the writer), beat width, and beats-per-line constants.
- The reader state enum (IDLE, REQ, RECV, DONE) stays local to the module.
- No sub-module: the state machine, beat counter and line register fit in one module, roughly 150 lines.

Test Plan:
- Reset, then reqcyc with addr=0x1000. reqack at the first REQ cycle; 8 back-to-back beats 0x11..0x88 → bus.req=0x1000 with READ_MEM_TAG; respack high on each beat; respcyc one cycle at T+10; data words 0..7 = 0x11..0x88.
- reqack delayed 5 cycles → bus.reqcyc, req and bid held stable for all 5 cycles; no respack while waiting.
- Beats with 3 idle cycles between each, plus one beat carrying WRITE_MEM_TAG mid-stream → wrong-tag beat gets no respack and is not stored; line still assembles the 8 valid beats in order.
- reqcyc pulsed during RECV with addr=0x2000 → ignored; no second bus request; after DONE, a new reqcyc issues req=0x2000.
- reset asserted after 4 beats → next cycle all bus outputs 0 and respcyc 0; a following full transaction completes correctly with counter restarted at 0.
- bus.respcyc asserted during REQ before reqack → no respack, data unchanged.

Source files
------------

// File: rtl/muskbus_reader_pkg.sv
// Shared Muskbus constants: transaction tags and line geometry.
package muskbus_reader_pkg;

  localparam int MB_BEATS  = 8;
  localparam int MB_BEAT_W = 64;
  localparam int MB_ADDR_W = 64;
  localparam int MB_TAG_W  = 4;

  localparam logic [MB_TAG_W-1:0] READ_MEM_TAG  = 4'h1;
  localparam logic [MB_TAG_W-1:0] WRITE_MEM_TAG = 4'h2;

endpackage

// File: rtl/muskbus_reader_if.sv
// Muskbus request/response channel. master = the client-side Top port.
interface muskbus_reader_if;
  import muskbus_reader_pkg::*;

  logic                 bid;
  logic                 reqcyc;
  logic [MB_TAG_W-1:0]  reqtag;
  logic [MB_ADDR_W-1:0] req;
  logic                 respack;
  logic                 reqack;
  logic                 respcyc;
  logic [MB_TAG_W-1:0]  resptag;
  logic [MB_BEAT_W-1:0] resp;

  modport master (
    output bid, reqcyc, reqtag, req, respack,
    input  reqack, respcyc, resptag, resp
  );

  modport slave (
    input  bid, reqcyc, reqtag, req, respack,
    output reqack, respcyc, resptag, resp
  );

endinterface

// File: rtl/muskbus_reader.sv
// Muskbus line reader: one READ_MEM_TAG request, BEATS response beats,
// assembled line handed back to the client with a one-cycle respcyc.
//
// state | meaning
// IDLE  | waiting for a client read request
// REQ   | bidding with the line address until reqack
// RECV  | collecting and acknowledging response beats
// DONE  | line complete, respcyc pulse to client
module muskbus_reader
  import muskbus_reader_pkg::*;
#(
  parameter int BEATS  = MB_BEATS,
  parameter int BEAT_W = MB_BEAT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  muskbus_reader_if.master          bus,
  input  logic                      reqcyc,
  input  logic [MB_ADDR_W-1:0]      addr,
  output logic                      respcyc,
  output logic [0:BEATS*BEAT_W-1]   data
);

  localparam int CNT_W = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [MB_ADDR_W-1:0] addr_q;
  logic                 beat_ok;

  // A beat counts only in RECV with the read tag; never in a reset cycle.
  assign beat_ok = (state == RECV) && bus.respcyc &&
                   (bus.resptag == READ_MEM_TAG) && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Address latch, beat counter and line register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      addr_q <= '0;
      data   <= '0;
    end else begin
      if (state == IDLE && reqcyc) begin
        addr_q <= addr;
        cnt    <= '0;
      end
      if (beat_ok) begin
        for (int k = 0; k < BEATS; k++) begin
          if (cnt == CNT_W'(k)) data[k*BEAT_W +: BEAT_W] <= bus.resp;
        end
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next-state and bus/client output decode.
  always_comb begin
    state_nxt   = state;
    bus.bid     = 1'b0;
    bus.reqcyc  = 1'b0;
    bus.reqtag  = '0;
    bus.req     = '0;
    bus.respack = 1'b0;
    respcyc     = 1'b0;
    case (state)
      IDLE: begin
        if (reqcyc) state_nxt = REQ;
      end
      REQ: begin
        bus.bid    = 1'b1;
        bus.reqcyc = 1'b1;
        bus.reqtag = READ_MEM_TAG;
        bus.req    = addr_q;
        if (bus.reqack) state_nxt = RECV;
      end
      RECV: begin
        bus.respack = beat_ok;
        if (beat_ok && cnt == CNT_W'(BEATS-1)) state_nxt = DONE;
      end
      DONE: begin
        respcyc   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
